// File: rtl/wallace_final_adder.sv
// wallace_final_adder: serial CHUNK-bit carry-propagate adder that adds the two reduced Wallace rows into the product
module wallace_final_adder #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             carry_out
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, sum_q, sum_d, product_q, product_d;
  logic             carry_q, carry_d, carry_out_q, carry_out_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] sum_ins;
  logic             last;
  assign in_ready  = state_q == IDLE && !rst;
  assign out_valid = state_q == DONE;
  assign product   = product_q;
  assign carry_out = carry_out_q;
  assign last      = idx_q == IW'(NSLICE - 1);
  // one CHUNK-bit ripple slice; the carry between slices lives in carry_q
  always_comb begin
    slice = {1'b0, r1_q[idx_q*CHUNK +: CHUNK]} + {1'b0, r2_q[idx_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
    sum_ins = sum_q;
    sum_ins[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
  end
  // IDLE accepts a row pair, ADD walks the slices, DONE holds the result until taken
  always_comb begin
    state_d     = state_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    product_d   = product_q;
    carry_out_d = carry_out_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        r1_d    = r1;
        r2_d    = r2;
        sum_d   = '0;
        carry_d = 1'b0;
        idx_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        sum_d       = sum_ins;
        carry_d     = slice[CHUNK];
        idx_d       = last ? idx_q : idx_q + IW'(1);
        product_d   = last ? sum_ins : product_q;
        carry_out_d = last ? slice[CHUNK] : carry_out_q;
        state_d     = last ? DONE : ADD;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r1_q        <= '0;
      r2_q        <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      product_q   <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      product_q   <= product_d;
      carry_out_q <= carry_out_d;
    end
  end
endmodule

// File: tb/tb_wallace_final_adder.sv
// tb_wallace_final_adder: randomized and directed checks of the serial final adder at CHUNK = 4, 1, 3, 6, 12
module tb_wallace_final_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  iv, ordy;
  wire  [4:0]  ir, ov, co;
  logic [11:0] r1_a [5];
  logic [11:0] r2_a [5];
  wire  [11:0] prod [5];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  function automatic int ch_of(input int k);
    return k == 0 ? 4 : k == 1 ? 1 : k == 2 ? 3 : k == 3 ? 6 : 12;
  endfunction
  function automatic int ns_of(input int k);
    return 12 / ch_of(k);
  endfunction
  for (genvar g = 0; g < 5; g++) begin : gd
    wallace_final_adder #(
      .WIDTH(12),
      .CHUNK(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 3 : g == 3 ? 6 : 12)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .r1(r1_a[g]),
      .r2(r2_a[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .product(prod[g]),
      .carry_out(co[g])
    );
  end
  task automatic run_one(input int k, input logic [11:0] a, input logic [11:0] b, output logic [12:0] res, output int lat);
    int w;
    @(negedge clk);
    iv[k] = 1'b1;
    r1_a[k] = a;
    r2_a[k] = b;
    ordy[k] = 1'b1;
    w = 0;
    while (!ir[k] && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    iv[k] = 1'b0;
    r1_a[k] = 12'($urandom);
    r2_a[k] = 12'($urandom);
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {co[k], prod[k]};
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    iv = '1;
    ordy = '0;
    for (int k = 0; k < 5; k++) begin
      r1_a[k] = 12'hFFF;
      r2_a[k] = 12'hFFF;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks += 4;
      if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov[k]); end
      if (prod[k] !== 12'h000) begin errors++; $display("FAIL reset_product[%0d]: got %h expected 000", k, prod[k]); end
      if (co[k] !== 1'b0) begin errors++; $display("FAIL reset_carry_out[%0d]: got %b expected 0", k, co[k]); end
      if (ir[k] !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low[%0d]: got %b expected 0", k, ir[k]); end
    end
    rst = 1'b0;
    iv = '0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ir[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready_idle[%0d]: got %b expected 1", k, ir[k]); end
    end
  endtask
  task automatic test_latency();
    logic [12:0] res;
    int lat;
    for (int k = 0; k < 5; k++) begin
      run_one(k, 12'hF81, 12'h000, res, lat);
      checks += 4;
      if (lat != ns_of(k)) begin errors++; $display("FAIL latency[%0d]: got %0d cycles expected %0d", k, lat, ns_of(k)); end
      if (res !== 13'h0F81) begin errors++; $display("FAIL latency_result[%0d]: got %h expected 0f81", k, res); end
      if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin errors++; $display("FAIL post_handshake[%0d]: got out_valid=%b in_ready=%b expected 0 1", k, ov[k], ir[k]); end
      if (prod[k] !== 12'hF81) begin errors++; $display("FAIL product_hold[%0d]: got %h expected f81", k, prod[k]); end
    end
  endtask
  task automatic test_carry();
    logic [11:0] da [3] = '{12'h0FF, 12'h7FF, 12'hFFF};
    logic [11:0] db [3] = '{12'h001, 12'h7FF, 12'h001};
    logic [11:0] a, b;
    logic [12:0] res, exp;
    int lat;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) begin
        a = i < 3 ? da[i] : 12'($urandom);
        b = i < 3 ? db[i] : 12'($urandom);
        exp = 13'(a) + 13'(b);
        run_one(k, a, b, res, lat);
        checks++;
        if (res !== exp) begin errors++; $display("FAIL carry[%0d] %h+%h: got %h expected %h", k, a, b, res, exp); end
      end
    end
  endtask
  task automatic test_backpressure();
    int w;
    @(negedge clk);
    iv[0] = 1'b1;
    r1_a[0] = 12'h123;
    r2_a[0] = 12'h456;
    ordy[0] = 1'b0;
    @(negedge clk);
    w = 0;
    while (!ov[0] && w < 20) begin
      r1_a[0] = 12'($urandom);
      r2_a[0] = 12'($urandom);
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (ov[0] !== 1'b1) begin errors++; $display("FAIL stall_out_valid cycle %0d: got %b expected 1", i, ov[0]); end
      if (ir[0] !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d: got %b expected 0", i, ir[0]); end
      if ({co[0], prod[0]} !== 13'h0579) begin errors++; $display("FAIL stall_result cycle %0d: got %h expected 0579", i, {co[0], prod[0]}); end
      r1_a[0] = 12'($urandom);
      r2_a[0] = 12'($urandom);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    iv[0] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin errors++; $display("FAIL stall_release: got out_valid=%b in_ready=%b expected 0 1", ov[0], ir[0]); end
    if (prod[0] !== 12'h579) begin errors++; $display("FAIL stall_release_product: got %h expected 579", prod[0]); end
    ordy[0] = 1'b0;
  endtask
  task automatic test_reset_mid_add();
    @(negedge clk);
    iv[0] = 1'b1;
    r1_a[0] = 12'hABC;
    r2_a[0] = 12'h111;
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", ov[0]); end
    if (prod[0] !== 12'h000) begin errors++; $display("FAIL abort_product: got %h expected 000", prod[0]); end
    if (co[0] !== 1'b0) begin errors++; $display("FAIL abort_carry_out: got %b expected 0", co[0]); end
    if (ir[0] !== 1'b0) begin errors++; $display("FAIL abort_in_ready_in_reset: got %b expected 0", ir[0]); end
    rst = 1'b0;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL abort_idle: got in_ready=%b expected 1", ir[0]); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b0 || prod[0] !== 12'h000) begin errors++; $display("FAIL abort_no_output cycle %0d: got out_valid=%b product=%h expected 0 000", i, ov[0], prod[0]); end
    end
    ordy[0] = 1'b0;
  endtask
  task automatic test_sweep(input int k, input int n, input bit full);
    logic [12:0] q [$];
    logic [12:0] e;
    logic [11:0] na, nb;
    int sent, got, cyc, a, b, p, x;
    bit have;
    sent = 0;
    got = 0;
    cyc = 0;
    have = 1'b0;
    p = 0;
    while (got < n && cyc < n * 40 + 200) begin
      @(negedge clk);
      cyc++;
      if (sent < n && !have) begin
        a = full ? sent / 64 : int'($urandom_range(63));
        b = full ? sent % 64 : int'($urandom_range(63));
        p = a * b;
        x = int'($urandom_range(p));
        na = 12'(x);
        nb = 12'(p - x);
        have = 1'b1;
      end
      iv[k] = have && ($urandom_range(3) != 0);
      r1_a[k] = iv[k] ? na : 12'($urandom);
      r2_a[k] = iv[k] ? nb : 12'($urandom);
      ordy[k] = $urandom_range(3) != 0;
      checks++;
      if (ov[k] && ir[k]) begin errors++; $display("FAIL sweep_invariant[%0d]: got out_valid=1 in_ready=1 expected not both", k); end
      if (iv[k] && ir[k]) begin
        q.push_back(13'(p));
        sent++;
        have = 1'b0;
      end
      if (ov[k] && ordy[k]) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sweep_spurious[%0d]: got output %h expected none", k, {co[k], prod[k]});
        end else begin
          e = q.pop_front();
          if ({co[k], prod[k]} !== e) begin errors++; $display("FAIL sweep_product[%0d] op %0d: got %h expected %h", k, got - 1, {co[k], prod[k]}, e); end
        end
      end
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
    checks++;
    if (got < n) begin errors++; $display("FAIL sweep_timeout[%0d]: got %0d outputs expected %0d", k, got, n); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_carry();
    test_backpressure();
    test_reset_mid_add();
    test_sweep(0, 4096, 1'b1);
    for (int k = 1; k < 5; k++) test_sweep(k, 384, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
